// File: rtl/serial_shift_sequencer_16_bit_if.sv
// Handshake and shift-strobe bundle for serial_shift_sequencer_16_bit.
// The requester/bench drives the master side; the sequencer is the slave.
interface serial_shift_sequencer_16_bit_if;
  logic        enable;
  logic        data_valid;
  logic [15:0] data;
  logic [3:0]  gap_cycles;
  logic        data_ready;
  logic        shift_data_signal;
  logic        serial_data;
  logic [4:0]  bit_count;
  logic        busy;
  logic        frame_done;

  modport slave (
    input  enable, data_valid, data, gap_cycles,
    output data_ready, shift_data_signal, serial_data, bit_count, busy, frame_done
  );

  modport master (
    output enable, data_valid, data, gap_cycles,
    input  data_ready, shift_data_signal, serial_data, bit_count, busy, frame_done
  );
endinterface

// File: rtl/serial_shift_sequencer_16_bit.sv
// Serializes a 16-bit word MSB first with a shift strobe, then idles for a latched gap.
// Define SERIAL_SHIFT_SEQUENCER_PARITY_EN to append an even-parity bit as a 17th shift.
module serial_shift_sequencer_16_bit (
  input  logic                           i_clk,
  input  logic                           i_rst,
  serial_shift_sequencer_16_bit_if.slave bus
);

`ifdef SERIAL_SHIFT_SEQUENCER_PARITY_EN
  localparam logic [4:0] LAST_IDX = 5'd16;
`else
  localparam logic [4:0] LAST_IDX = 5'd15;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t      r_state;
  logic [15:0] r_word;
  logic [3:0]  r_gap;
  logic [3:0]  r_gap_cnt;
  logic [4:0]  r_cnt;
  logic        r_shift;
  logic        r_sd;
  logic        r_done;

  state_t      w_next;
  logic [15:0] w_word;
  logic [3:0]  w_gap;
  logic [3:0]  w_gap_cnt;
  logic [4:0]  w_cnt;
  logic        w_shift;
  logic        w_sd;
  logic        w_done;
  logic        w_ready;
  logic        w_hs;
  logic [4:0]  w_nidx;
  logic        w_nbit;

  assign w_ready = (r_state == IDLE) && bus.enable;
  assign w_hs    = bus.data_valid && w_ready;
  assign w_nidx  = r_cnt + 5'd1;
  // Index 16 only occurs with parity compiled in; it carries the XOR of the word.
  assign w_nbit  = (w_nidx == 5'd16) ? ^r_word : r_word[4'd15 - w_nidx[3:0]];

  always_comb begin
    w_next    = r_state;
    w_word    = r_word;
    w_gap     = r_gap;
    w_gap_cnt = r_gap_cnt;
    w_cnt     = r_cnt;
    w_shift   = r_shift;
    w_sd      = r_sd;
    w_done    = 1'b0;
    if (!bus.enable) begin
      w_done = r_done;
    end else begin
      case (r_state)
        IDLE: begin
          w_shift = 1'b0;
          w_sd    = 1'b0;
          if (w_hs) begin
            w_next    = SHIFT;
            w_word    = bus.data;
            w_gap     = bus.gap_cycles;
            w_gap_cnt = bus.gap_cycles;
            w_cnt     = 5'd0;
            w_shift   = 1'b1;
            w_sd      = bus.data[15];
          end
        end
        SHIFT: begin
          if (r_cnt == LAST_IDX) begin
            w_shift = 1'b0;
            w_sd    = 1'b0;
            w_cnt   = 5'd0;
            w_done  = 1'b1;
            w_next  = (r_gap != 4'd0) ? GAP : IDLE;
          end else begin
            w_cnt   = w_nidx;
            w_sd    = w_nbit;
            w_shift = 1'b1;
          end
        end
        GAP: begin
          // The Done cycle is not counted: gap_cycles idle cycles follow it.
          if (r_gap_cnt == 4'd0) w_next = IDLE;
          else                   w_gap_cnt = r_gap_cnt - 4'd1;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_word    <= 16'd0;
      r_gap     <= 4'd0;
      r_gap_cnt <= 4'd0;
      r_cnt     <= 5'd0;
      r_shift   <= 1'b0;
      r_sd      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_word    <= w_word;
      r_gap     <= w_gap;
      r_gap_cnt <= w_gap_cnt;
      r_cnt     <= w_cnt;
      r_shift   <= w_shift;
      r_sd      <= w_sd;
      r_done    <= w_done;
    end
  end

  // Strobe and done are gated so a frozen sequencer never strobes the shift register.
  assign bus.data_ready        = w_ready;
  assign bus.shift_data_signal = r_shift && bus.enable;
  assign bus.serial_data       = r_sd;
  assign bus.bit_count         = r_cnt;
  assign bus.busy              = (r_state != IDLE);
  assign bus.frame_done        = r_done && bus.enable;

endmodule

// File: tb/tb_serial_shift_sequencer_16_bit.sv
// Randomized scoreboard bench for serial_shift_sequencer_16_bit against a cycle-count model.
module tb_serial_shift_sequencer_16_bit;
`ifdef SERIAL_SHIFT_SEQUENCER_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_shift_sequencer_16_bit_if bus();
  serial_shift_sequencer_16_bit dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

  typedef struct { int idx; bit b; } exp_t;
  exp_t q[$];

  int checks = 0;
  int passes = 0;
  bit started = 0;

  // Model: frame occupies NB enabled edges, then gap+1 more when gap is nonzero.
  int m_rem = 0;
  int m_k = 0;
  bit m_done = 0;
  int m_hs_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_k = 0; m_done = 0; q.delete();
    end else if (bus.enable) begin
      m_done = 0;
      if (m_rem == 0) begin
        if (bus.data_valid) begin
          logic [15:0] w;
          w = bus.data;
          for (int i = 0; i < NB; i++) begin
            exp_t e;
            e.idx = i;
            e.b = (i < 16) ? w[15 - i] : ^w;
            q.push_back(e);
          end
          m_rem = NB + ((bus.gap_cycles != 0) ? int'(bus.gap_cycles) + 1 : 0);
          m_k = 0;
          m_hs_cnt++;
        end
      end else begin
        m_rem--;
        m_k++;
        if (m_k == NB) m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit insh;
    exp_t e;
    if (started) begin
      insh = (m_rem != 0) && (m_k < NB);
      chk("ready", int'(bus.data_ready), int'(m_rem == 0 && bus.enable));
      chk("busy", int'(bus.busy), int'(m_rem != 0));
      chk("strobe", int'(bus.shift_data_signal), int'(insh && bus.enable));
      chk("done", int'(bus.frame_done), int'(m_done && bus.enable));
      if (!insh) chk("serial_idle", int'(bus.serial_data), 0);
      if (bus.shift_data_signal) begin
        if (q.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          e = q.pop_front();
          chk("bit_idx", int'(bus.bit_count), e.idx);
          chk("bit_val", int'(bus.serial_data), int'(e.b));
        end
      end
    end
  end

  task automatic tick(input bit rnd_en);
    @(posedge clk);
    #1;
    if (rnd_en) bus.enable = ($urandom_range(0, 7) != 0);
  endtask

  task automatic send(input logic [15:0] w, input logic [3:0] g, input bit rnd_en);
    int c0, n;
    c0 = m_hs_cnt;
    n = 0;
    bus.data_valid = 1'b1;
    bus.data = w;
    bus.gap_cycles = g;
    while (m_hs_cnt == c0 && n < 300) begin
      tick(rnd_en);
      n++;
    end
    if (m_hs_cnt == c0) chk("handshake_timeout", 0, 1);
    bus.data_valid = 1'b0;
    bus.data = 16'($urandom);
    bus.gap_cycles = 4'($urandom);
  endtask

  task automatic wait_idle(input bit rnd_en);
    int n;
    n = 0;
    while (m_rem != 0 && n < 400) begin
      tick(rnd_en);
      n++;
    end
    if (m_rem != 0) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.data_valid = 1'b0;
    bus.data = 16'h0;
    bus.gap_cycles = 4'h0;
    tick(0);
    started = 1;
    tick(0);
    chk("rst_bit_count", int'(bus.bit_count), 0);
    chk("rst_serial", int'(bus.serial_data), 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    tick(0);

    send(16'hA5C3, 4'd0, 0);
    send(16'h1234, 4'd0, 0);
    wait_idle(0);
    send(16'hFFFF, 4'd3, 0);
    wait_idle(0);
    tick(0);

    send(16'h8001, 4'd0, 0);
    repeat (7) tick(0);
    bus.enable = 1'b0;
    repeat (5) tick(0);
    bus.enable = 1'b1;
    wait_idle(0);

    send(16'hDEAD, 4'd2, 0);
    repeat (9) tick(0);
    rst = 1'b1;
    tick(0);
    rst = 1'b0;
    tick(0);
    chk("midreset_bit_count", int'(bus.bit_count), 0);
    send(16'h3C5A, 4'd0, 0);

    send(16'h0F0F, 4'd1, 0);
    bus.data_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.data = 16'($urandom);
      tick(0);
    end
    bus.data_valid = 1'b0;
    wait_idle(0);

    send(16'h0007, 4'd0, 0);
    send(16'h0003, 4'd0, 0);
    wait_idle(0);

    for (int f = 0; f < 60; f++) begin
      send(16'($urandom), 4'($urandom_range(0, 4)), 1);
      if ($urandom_range(0, 3) == 0) wait_idle(1);
    end
    bus.enable = 1'b1;
    wait_idle(0);
    repeat (3) tick(0);
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
